fight_referee: RTL and testbench

FIGHT_REFEREE -- requirements
Module: fight_referee

---
 rtl/fight_referee.sv | 164 ++++++++++++++++
 tb/tb_fight_referee.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fight_referee.sv
// Match referee for a two-player fighting game: sequences rounds, gates player
// commands into single-cycle issue windows and tallies round wins.
module fight_referee #(
  parameter int ROUND_TICKS   = 30,
  parameter int WINS_TO_MATCH = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       tick,
  input  logic [5:0] left_cmd,
  input  logic [5:0] right_cmd,
  input  logic [2:0] left_health,
  input  logic [2:0] right_health,
  output logic       players_rst_n,
  output logic [5:0] left_cmd_out,
  output logic [5:0] right_cmd_out,
  output logic [2:0] state,
  output logic [5:0] round_timer,
  output logic [2:0] round_num,
  output logic [1:0] left_wins,
  output logic [1:0] right_wins,
  output logic [1:0] winner
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] PRST       = 3'd1;
  localparam logic [2:0] FIGHT      = 3'd2;
  localparam logic [2:0] ISSUE      = 3'd3;
  localparam logic [2:0] SETTLE     = 3'd4;
  localparam logic [2:0] CHECK      = 3'd5;
  localparam logic [2:0] ROUND_END  = 3'd6;
  localparam logic [2:0] MATCH_OVER = 3'd7;

  localparam logic [5:0] TICKS_INIT = 6'(ROUND_TICKS);
  localparam logic [1:0] WINS_GOAL  = 2'(WINS_TO_MATCH);
  localparam logic [2:0] ROUND_MAX  = 3'(MAX_ROUNDS);

  // Round result encoding matches the winner output: 01 left, 10 right, 11 draw.
  localparam logic [1:0] RES_LEFT  = 2'b01;
  localparam logic [1:0] RES_RIGHT = 2'b10;
  localparam logic [1:0] RES_DRAW  = 2'b11;

  logic [5:0] left_reg, right_reg;
  logic       prst_cnt, settle_cnt;
  logic [1:0] round_result;
  logic [1:0] left_wins_next, right_wins_next, winner_next;
  logic       left_ko, right_ko, match_done;

  function automatic logic [5:0] sanitise(input logic [5:0] c);
    logic one_hot;
    one_hot = (c != 6'd0) && ((c & (c - 6'd1)) == 6'd0);
    return one_hot ? c : 6'd0;
  endfunction

  // Health 7 is how a player block shows an underflowed (below zero) health.
  assign left_ko  = (left_health == 3'd0) || (left_health == 3'd7);
  assign right_ko = (right_health == 3'd0) || (right_health == 3'd7);

  assign players_rst_n = (state != IDLE) && (state != PRST);
  assign left_cmd_out  = (state == ISSUE) ? left_reg : 6'd0;
  assign right_cmd_out = (state == ISSUE) ? right_reg : 6'd0;

  always_comb begin
    left_wins_next  = left_wins;
    right_wins_next = right_wins;
    if (round_result == RES_LEFT && left_wins != 2'd3)
      left_wins_next = left_wins + 2'd1;
    if (round_result == RES_RIGHT && right_wins != 2'd3)
      right_wins_next = right_wins + 2'd1;
    match_done = (left_wins_next == WINS_GOAL) || (right_wins_next == WINS_GOAL) ||
                 (round_num == ROUND_MAX);
    if (left_wins_next > right_wins_next)
      winner_next = RES_LEFT;
    else if (right_wins_next > left_wins_next)
      winner_next = RES_RIGHT;
    else
      winner_next = RES_DRAW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      left_reg     <= 6'd0;
      right_reg    <= 6'd0;
      prst_cnt     <= 1'b0;
      settle_cnt   <= 1'b0;
      round_result <= 2'b00;
      round_timer  <= 6'd0;
      round_num    <= 3'd0;
      left_wins    <= 2'd0;
      right_wins   <= 2'd0;
      winner       <= 2'b00;
    end else begin
      case (state)
        IDLE, MATCH_OVER: begin
          if (start) begin
            left_wins  <= 2'd0;
            right_wins <= 2'd0;
            winner     <= 2'b00;
            round_num  <= 3'd1;
            prst_cnt   <= 1'b0;
            state      <= PRST;
          end
        end
        PRST: begin
          round_timer <= TICKS_INIT;
          prst_cnt    <= ~prst_cnt;
          if (prst_cnt) state <= FIGHT;
        end
        FIGHT: begin
          if (tick) begin
            left_reg    <= sanitise(left_cmd);
            right_reg   <= sanitise(right_cmd);
            round_timer <= (round_timer == 6'd0) ? 6'd0 : round_timer - 6'd1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          settle_cnt <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          settle_cnt <= ~settle_cnt;
          if (settle_cnt) state <= CHECK;
        end
        CHECK: begin
          if (left_ko || right_ko || round_timer == 6'd0) begin
            if (left_ko && right_ko)
              round_result <= RES_DRAW;
            else if (right_ko)
              round_result <= RES_LEFT;
            else if (left_ko)
              round_result <= RES_RIGHT;
            else if (left_health > right_health)
              round_result <= RES_LEFT;
            else if (right_health > left_health)
              round_result <= RES_RIGHT;
            else
              round_result <= RES_DRAW;
            state <= ROUND_END;
          end else begin
            state <= FIGHT;
          end
        end
        ROUND_END: begin
          left_wins  <= left_wins_next;
          right_wins <= right_wins_next;
          if (match_done) begin
            winner <= winner_next;
            state  <= MATCH_OVER;
          end else begin
            round_num <= round_num + 3'd1;
            prst_cnt  <= 1'b0;
            state     <= PRST;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fight_referee.sv
// Bench for fight_referee: tick-vector table, issue-window scoreboard and
// hand-written sequences for round/match transitions and mid-round reset.
module tb_fight_referee;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRST = 3'd1, S_FIGHT = 3'd2, S_ISSUE = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4, S_ROUND_END = 3'd6, S_MATCH_OVER = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [5:0] left_cmd = 6'd0, right_cmd = 6'd0;
  logic [2:0] left_health = 3'd3, right_health = 3'd3;
  logic       players_rst_n;
  logic [5:0] left_cmd_out, right_cmd_out;
  logic [2:0] state, round_num;
  logic [5:0] round_timer;
  logic [1:0] left_wins, right_wins, winner;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  fight_referee #(.ROUND_TICKS(30), .WINS_TO_MATCH(2), .MAX_ROUNDS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
    .left_cmd(left_cmd), .right_cmd(right_cmd),
    .left_health(left_health), .right_health(right_health),
    .players_rst_n(players_rst_n),
    .left_cmd_out(left_cmd_out), .right_cmd_out(right_cmd_out),
    .state(state), .round_timer(round_timer), .round_num(round_num),
    .left_wins(left_wins), .right_wins(right_wins), .winner(winner)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ISSUE cycle pops one expected {left,right} pair; outside
  // ISSUE the gated commands must stay zero.
  always @(negedge clk) begin
    if (rst_n) begin
      if (state == S_ISSUE) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue_extra: got issue cycle %h/%h, expected none", left_cmd_out, right_cmd_out);
        end else begin
          chk("issue_cmds", {left_cmd_out, right_cmd_out}, exp_q.pop_front());
        end
      end else begin
        chk("cmd_gated", {left_cmd_out, right_cmd_out}, 12'd0);
      end
    end
  end

  // Driver tasks
  task automatic wait_state(input logic [2:0] s, input string name);
    int n = 0;
    while (state != s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, state, s);
  endtask

  task automatic start_match();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_state(S_FIGHT, "reach_fight");
  endtask

  task automatic step(input logic [5:0] lc, input logic [5:0] rc, input logic [2:0] lh,
                      input logic [2:0] rh, input logic [5:0] el, input logic [5:0] er,
                      output logic [2:0] after);
    int n = 0;
    wait_state(S_FIGHT, "step_in_fight");
    left_cmd = lc; right_cmd = rc; left_health = lh; right_health = rh;
    tick = 1'b1;
    exp_q.push_back({el, er});
    @(negedge clk);
    tick = 1'b0;
    left_cmd = $urandom_range(63, 0);
    right_cmd = $urandom_range(63, 0);
    do begin
      @(negedge clk);
      n++;
    end while (state != S_FIGHT && state != S_ROUND_END && n < 20);
    after = state;
  endtask

  typedef struct {
    logic [5:0] lc, rc;
    logic [2:0] lh, rh;
    logic [5:0] el, er;
    logic [2:0] es;
  } vec_t;

  vec_t vecs[6];
  logic [2:0] st;

  initial begin
    vecs[0] = '{6'b000011, 6'b000001, 3'd3, 3'd3, 6'b000000, 6'b000001, S_FIGHT};
    vecs[1] = '{6'b100000, 6'b000000, 3'd3, 3'd3, 6'b100000, 6'b000000, S_FIGHT};
    vecs[2] = '{6'b010000, 6'b110000, 3'd4, 3'd2, 6'b010000, 6'b000000, S_FIGHT};
    vecs[3] = '{6'b000100, 6'b001000, 3'd5, 3'd5, 6'b000100, 6'b001000, S_FIGHT};
    vecs[4] = '{6'b000010, 6'b111111, 3'd3, 3'd1, 6'b000010, 6'b000000, S_FIGHT};
    vecs[5] = '{6'b000001, 6'b000001, 3'd3, 3'd0, 6'b000001, 6'b000001, S_ROUND_END};

    // Reset values and idle hold
    #2;
    chk("rst_state", state, S_IDLE);
    chk("rst_prst_n", players_rst_n, 1'b0);
    chk("rst_round", {round_num, round_timer, left_wins, right_wins, winner}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", state, S_IDLE);
    chk("idle_prst_n", players_rst_n, 1'b0);

    // Start: two cycles of player reset, then FIGHT
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("prst1", {state, players_rst_n, round_num}, {S_PRST, 1'b0, 3'd1});
    @(negedge clk);
    chk("prst2", {state, players_rst_n}, {S_PRST, 1'b0});
    @(negedge clk);
    chk("fight_entry", {state, players_rst_n, round_timer}, {S_FIGHT, 1'b1, 6'd30});

    // Round 1 from the vector table, right KO on the last vector
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].lc, vecs[i].rc, vecs[i].lh, vecs[i].rh, vecs[i].el, vecs[i].er, st);
      chk($sformatf("vec%0d_state", i), st, vecs[i].es);
      chk($sformatf("vec%0d_timer", i), round_timer, 6'(29 - i));
    end

    // tick and start held through ROUND_END and PRST must be ignored
    tick = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("re_to_prst", {state, round_num, left_wins, right_wins}, {S_PRST, 3'd2, 2'd1, 2'd0});
    repeat (2) @(negedge clk);
    tick = 1'b0;
    start = 1'b0;
    chk("tick_ignored", {state, round_timer, round_num, left_wins}, {S_FIGHT, 6'd30, 3'd2, 2'd1});

    // Round 2: second left win ends the match
    step(6'b000001, 6'b000000, 3'd2, 3'd0, 6'b000001, 6'b000000, st);
    chk("r2_end", st, S_ROUND_END);
    @(negedge clk);
    chk("match_left", {state, left_wins, right_wins, winner}, {S_MATCH_OVER, 2'd2, 2'd0, 2'b01});
    repeat (3) @(negedge clk);
    chk("match_hold", {state, winner, players_rst_n}, {S_MATCH_OVER, 2'b01, 1'b1});

    // New match: 30-tick timeout with equal health is a draw
    start_match();
    chk("restart", {round_num, left_wins, right_wins, winner}, {3'd1, 2'd0, 2'd0, 2'b00});
    for (int i = 0; i < 30; i++) begin
      step(6'b000100, 6'b000010, 3'd3, 3'd3, 6'b000100, 6'b000010, st);
      if (i < 29) chk("timeout_run", st, S_FIGHT);
    end
    chk("timeout_end", {st, round_timer}, {S_ROUND_END, 6'd0});
    @(negedge clk);
    chk("timeout_draw", {state, round_num, left_wins, right_wins}, {S_PRST, 3'd2, 2'd0, 2'd0});

    // Rounds 2..5: both sides underflow to 7, all draws, match ends at round limit
    for (int r = 2; r <= 5; r++) begin
      step(6'b001000, 6'b001000, 3'd7, 3'd7, 6'b001000, 6'b001000, st);
      chk("double_ko", {st, round_num}, {S_ROUND_END, 3'(r)});
      @(negedge clk);
    end
    chk("draw_match", {state, round_num, left_wins, right_wins, winner},
        {S_MATCH_OVER, 3'd5, 2'd0, 2'd0, 2'b11});

    // Timeout decided on health: right higher wins the round
    start_match();
    for (int i = 0; i < 30; i++)
      step(6'b000000, 6'b000000, 3'd2, 3'd5, 6'b000000, 6'b000000, st);
    @(negedge clk);
    chk("timeout_health", {state, left_wins, right_wins}, {S_PRST, 2'd0, 2'd1});

    // Asynchronous reset during SETTLE
    wait_state(S_FIGHT, "pre_rst_fight");
    step(6'b010000, 6'b000001, 3'd4, 3'd4, 6'b010000, 6'b000001, st);
    wait_state(S_FIGHT, "pre_rst_fight2");
    tick = 1'b1;
    exp_q.push_back({6'b000000, 6'b000000});
    left_cmd = 6'd0; right_cmd = 6'd0;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("in_settle", state, S_SETTLE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {state, players_rst_n, left_cmd_out, right_cmd_out},
        {S_IDLE, 1'b0, 6'd0, 6'd0});
    chk("async_rst_cnt", {round_timer, round_num, left_wins, right_wins, winner}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", {state, players_rst_n}, {S_IDLE, 1'b0});

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
